// File: rtl/barcode_rdr_pkg.sv
// Shared types and constants for the barcode station-ID reader.
package barcode_rdr_pkg;

    localparam int unsigned TMR_W = 22;

    // Station IDs are only accepted when the two MSBs match this prefix.
    localparam logic [1:0] ID_PREFIX = 2'b00;

    typedef enum logic [1:0] {
        StIdle,
        StStartLow,
        StWaitFall,
        StBitTime
    } state_t;

endpackage

// File: rtl/bc_sync.sv
// Three-flop synchronizer for the raw barcode line with fall/rise strobes.
module bc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic sync,
    output logic fall,
    output logic rise
);

    logic [2:0] ff_q;

    // Preset to idle-high so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= 3'b111;
        end else begin
            ff_q <= {ff_q[1:0], in};
        end
    end

    assign sync = ff_q[1];
    assign fall = ff_q[2] & ~ff_q[1];
    assign rise = ~ff_q[2] & ff_q[1];

endmodule

// File: rtl/barcode_rdr.sv
// Pulse-width barcode decoder: start bit sets the half-period P, data bits sampled P after each fall.
module barcode_rdr #(
    parameter int unsigned TMR_W = barcode_rdr_pkg::TMR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    import barcode_rdr_pkg::*;

    logic             bc_s;
    logic             bc_fall;
    logic             bc_rise;
    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] per_q;
    logic [TMR_W-1:0] btmr_q;
    logic [3:0]       cnt_q;
    logic [7:0]       shift_q;
    logic             done_q;

    bc_sync u_bc_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (BC),
        .sync  (bc_s),
        .fall  (bc_fall),
        .rise  (bc_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            per_q   <= '0;
            btmr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ID      <= 8'h00;
            ID_vld  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A completing valid frame takes priority over the consumer clear.
            if (done_q && (shift_q[7:6] == ID_PREFIX)) begin
                ID     <= shift_q;
                ID_vld <= 1'b1;
            end else if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (bc_fall) begin
                        tmr_q   <= '0;
                        state_q <= StStartLow;
                    end
                end
                StStartLow: begin
                    if (tmr_q == '1) begin
                        state_q <= StIdle;
                    end else if (bc_rise) begin
                        per_q   <= tmr_q;
                        cnt_q   <= '0;
                        state_q <= StWaitFall;
                    end else if (!bc_s) begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StWaitFall: begin
                    if (bc_fall) begin
                        btmr_q  <= '0;
                        state_q <= StBitTime;
                    end
                end
                StBitTime: begin
                    // per_q can never be all-ones plus one, so btmr_q stops before wrapping.
                    if (btmr_q == per_q) begin
                        shift_q <= {shift_q[6:0], bc_s};
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StWaitFall;
                        end
                    end else begin
                        btmr_q <= btmr_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_barcode_rdr.sv
// Directed plus randomized frame bench for barcode_rdr against a frame-level reference model.
module tb_barcode_rdr;

    logic       clk;
    logic       rst_n;
    logic       BC;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;

    int n_cmp;
    int n_fail;

    logic [7:0] exp_id;
    logic       exp_vld;

    barcode_rdr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive BC to lvl now and keep it for n clock cycles.
    task automatic hold(input logic lvl, input int n);
        BC = lvl;
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Sends start bit plus bits [7:lsb]; with tail=0 the final high gap is left to the caller.
    task automatic send_bits(input logic [7:0] data, input int s, input int per,
                             input int l1, input int l0, input int lsb, input bit tail);
        int len;
        hold(1'b0, s);
        hold(1'b1, per - s);
        for (int i = 7; i >= lsb; i--) begin
            len = data[i] ? l1 : l0;
            hold(1'b0, len);
            if (i != lsb || tail) hold(1'b1, per - len);
        end
    endtask

    // Reference: a received frame updates the outputs only when its top two bits are zero.
    function automatic void model_frame(input logic [7:0] data);
        if (data < 8'h40) begin
            exp_id  = data;
            exp_vld = 1'b1;
        end
    endfunction

    task automatic frame(input logic [7:0] data, input int s, input string tag);
        send_bits(data, s, 2 * s, s / 2, (3 * s) / 2, 0, 1'b1);
        model_frame(data);
        check({tag, "_id"}, {24'h0, ID}, {24'h0, exp_id});
        check({tag, "_vld"}, {31'h0, ID_vld}, {31'h0, exp_vld});
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        clr_ID_vld = 1'b1;
        @(posedge clk);
        #1;
        clr_ID_vld = 1'b0;
        exp_vld = 1'b0;
        check(tag, {31'h0, ID_vld}, {31'h0, exp_vld});
        #2;
    endtask

    initial begin
        logic [7:0] rnd;
        int         s;
        bit         got;

        n_cmp      = 0;
        n_fail     = 0;
        exp_id     = 8'h00;
        exp_vld    = 1'b0;
        rst_n      = 1'b0;
        BC         = 1'b1;
        clr_ID_vld = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_id", {24'h0, ID}, 32'h0);
        check("reset_vld", {31'h0, ID_vld}, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        hold(1'b1, 5);
        check("post_reset_vld", {31'h0, ID_vld}, 32'h0);

        frame(8'h25, 1000, "long_25");
        frame(8'hA5, 1000, "long_a5_bad_prefix");

        frame(8'h12, 100, "f12");
        frame(8'h3F, 100, "f3f_overwrite");
        pulse_clr("clr_after_3f");
        check("clr_keeps_id", {24'h0, ID}, {24'h0, exp_id});

        // Clear held high across completion: the set must still be visible for one cycle.
        clr_ID_vld = 1'b1;
        send_bits(8'h07, 100, 200, 50, 150, 0, 1'b0);
        BC  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ID_vld === 1'b1) got = 1'b1;
        end
        check("set_wins_vld", {31'h0, got}, 32'h1);
        check("set_wins_id", {24'h0, ID}, 32'h07);
        @(posedge clk);
        #1;
        check("clr_after_set", {31'h0, ID_vld}, 32'h0);
        clr_ID_vld = 1'b0;
        exp_id     = 8'h07;
        exp_vld    = 1'b0;
        #2;
        hold(1'b1, 200);

        // Reset in the middle of a frame discards it and clears the outputs.
        send_bits(8'h15, 100, 200, 50, 150, 4, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_id", {24'h0, ID}, 32'h0);
        check("midframe_rst_vld", {31'h0, ID_vld}, 32'h0);
        exp_id  = 8'h00;
        exp_vld = 1'b0;
        hold(1'b1, 10);
        rst_n = 1'b1;
        hold(1'b1, 10);
        frame(8'h15, 100, "after_rst_15");

        frame(8'h2A, 20, "min_period_2a");

        for (int k = 0; k < 10; k++) begin
            rnd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rnd[7:6] = 2'b00;
            s = $urandom_range(20, 80);
            frame(rnd, s, "rand");
            if ($urandom_range(0, 2) == 0) pulse_clr("rand_clr");
            hold(1'b1, $urandom_range(1, 30));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
